// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator and later multi-voice channels.
// Holds the state encoding, the datapath widths and the sample encoder.
package tone_pkg;

    localparam int SAMPLE_W = 8;
    localparam int VOL_W    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } tone_state_t;

    // Signed amplitude for a state: +vol in HIGH, -vol in LOW, silence otherwise.
    function automatic logic [SAMPLE_W-1:0] sample_of(input tone_state_t s,
                                                       input logic [VOL_W-1:0] v);
        logic [SAMPLE_W-1:0] mag;
        mag = SAMPLE_W'(v);
        case (s)
            HIGH:    return mag;
            LOW:     return -mag;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: tick is high for one clk cycle in every DIV cycles.
// Latency: first tick lands DIV cycles after reset release; DIV=1 ticks every cycle.
// Backpressure: none, the divider never stalls.
module tick_divider #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator with latched half-period and volume per half.
// Latency: outputs registered, one clk after the tick that changes state.
// Backpressure: none; a tone only starts or stops on a half boundary tick.
module tone_generator
    import tone_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int HP_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HP_W-1:0]     half_period,
    input  logic                enable,
    input  logic [VOL_W-1:0]    volume,
    output logic                wave,
    output logic [SAMPLE_W-1:0] sample,
    output logic                wave_edge,
    output logic                busy
);

    logic                tick;
    tone_state_t         state_q, state_d;
    logic [HP_W-1:0]     cnt_q, cnt_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [VOL_W-1:0]    vol_q, vol_d;
    logic                start_ok;
    logic                wave_d;
    logic                wave_q;
    logic                edge_q;
    logic [SAMPLE_W-1:0] sample_q;

    tick_divider #(
        .DIV (PRESCALE)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hp_d     = hp_q;
        vol_d    = vol_q;
        start_ok = enable && (half_period != '0);

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        hp_d    = half_period;
                        vol_d   = volume;
                        cnt_d   = HP_W'(1);
                        state_d = HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (cnt_q != hp_q) begin
                        cnt_d = cnt_q + HP_W'(1);
                    end else if (start_ok) begin
                        // Half boundary: inputs are sampled only here.
                        hp_d    = half_period;
                        vol_d   = volume;
                        cnt_d   = HP_W'(1);
                        state_d = (state_q == HIGH) ? LOW : HIGH;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        wave_d = (state_d == HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hp_q     <= '0;
            vol_q    <= '0;
            wave_q   <= 1'b0;
            edge_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hp_q     <= hp_d;
            vol_q    <= vol_d;
            wave_q   <= wave_d;
            edge_q   <= wave_d ^ wave_q;
            sample_q <= sample_of(state_d, vol_d);
        end
    end

    assign wave      = wave_q;
    assign wave_edge = edge_q;
    assign sample    = sample_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_tone_generator;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] hp1;
    logic       en1;
    logic [6:0] vol1;
    logic       wave1;
    logic [7:0] sample1;
    logic       edge1;
    logic       busy1;

    logic [7:0] hp4;
    logic       en4;
    logic [6:0] vol4;
    logic       wave4;
    logic [7:0] sample4;
    logic       edge4;
    logic       busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_generator #(.PRESCALE(1), .HP_W(8)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .half_period (hp1),
        .enable      (en1),
        .volume      (vol1),
        .wave        (wave1),
        .sample      (sample1),
        .wave_edge   (edge1),
        .busy        (busy1)
    );

    tone_generator #(.PRESCALE(4), .HP_W(8)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .half_period (hp4),
        .enable      (en4),
        .volume      (vol4),
        .wave        (wave4),
        .sample      (sample4),
        .wave_edge   (edge4),
        .busy        (busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count negedges for which dut1's wave (or sample) holds its current value.
    task automatic run_len(input int start, input bit on_wave, output int n);
        logic [7:0] ref_v;
        logic [7:0] cur;
        ref_v = on_wave ? {7'd0, wave1} : sample1;
        n = start;
        do begin
            n++;
            @(negedge clk);
            cur = on_wave ? {7'd0, wave1} : sample1;
        end while (cur == ref_v && n < 300);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ecount;
        int bcount;

        rst_n = 1'b0;
        en1 = 1'b0; hp1 = 8'd0; vol1 = 7'd0;
        en4 = 1'b0; hp4 = 8'd0; vol4 = 7'd0;
        cyc(2);
        chk("reset_wave",   32'(wave1),   32'd0);
        chk("reset_sample", 32'(sample1), 32'd0);
        chk("reset_edge",   32'(edge1),   32'd0);
        chk("reset_busy",   32'(busy1),   32'd0);
        chk("reset_busy4",  32'(busy4),   32'd0);

        // Basic tone: 20-tick halves at volume 100.
        en1 = 1'b1; hp1 = 8'd20; vol1 = 7'd100;
        cyc(1);
        chk("held_in_reset_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("basic_first_wave",   32'(wave1),   32'd1);
        chk("basic_first_sample", 32'(sample1), 32'h64);
        chk("basic_first_edge",   32'(edge1),   32'd1);
        chk("basic_first_busy",   32'(busy1),   32'd1);
        cyc(1);
        chk("basic_no_edge_mid",  32'(edge1),   32'd0);
        run_len(1, 1'b1, n);
        chk("basic_high_len",     32'(n),       32'd20);
        chk("basic_low_wave",     32'(wave1),   32'd0);
        chk("basic_low_sample",   32'(sample1), 32'h9C);
        chk("basic_low_edge",     32'(edge1),   32'd1);
        run_len(0, 1'b1, n);
        chk("basic_low_len",      32'(n),       32'd20);
        chk("basic_high2_sample", 32'(sample1), 32'h64);

        // Mid-half change: 20 -> 5 at the 10th cycle of a HIGH half.
        cyc(9);
        hp1 = 8'd5;
        run_len(9, 1'b1, n);
        chk("midchg_high_len", 32'(n), 32'd20);
        run_len(0, 1'b1, n);
        chk("midchg_low_len",  32'(n), 32'd5);
        run_len(0, 1'b1, n);
        chk("midchg_high2_len", 32'(n), 32'd5);

        // Stop at boundary: enable dropped at cycle 3 of an 8-tick LOW half.
        hp1 = 8'd8;
        run_len(0, 1'b1, n);
        chk("stop_low5_len",  32'(n), 32'd5);
        run_len(0, 1'b1, n);
        chk("stop_high8_len", 32'(n), 32'd8);
        cyc(2);
        en1 = 1'b0;
        run_len(2, 1'b0, n);
        chk("stop_low8_len",     32'(n),       32'd8);
        chk("stop_idle_sample",  32'(sample1), 32'd0);
        chk("stop_idle_busy",    32'(busy1),   32'd0);
        chk("stop_idle_wave",    32'(wave1),   32'd0);
        chk("stop_idle_no_edge", 32'(edge1),   32'd0);
        cyc(3);
        chk("stop_stays_idle",   32'(busy1),   32'd0);

        // Volume boundaries, then a HIGH -> IDLE stop.
        en1 = 1'b1; hp1 = 8'd3; vol1 = 7'd127;
        cyc(1);
        chk("vol127_high_sample", 32'(sample1), 32'h7F);
        chk("vol127_high_wave",   32'(wave1),   32'd1);
        cyc(3);
        chk("vol127_low_sample",  32'(sample1), 32'h81);
        chk("vol127_low_wave",    32'(wave1),   32'd0);
        vol1 = 7'd0;
        cyc(3);
        chk("vol0_high_wave",   32'(wave1),   32'd1);
        chk("vol0_high_sample", 32'(sample1), 32'd0);
        chk("vol0_high_edge",   32'(edge1),   32'd1);
        cyc(3);
        chk("vol0_low_wave",    32'(wave1),   32'd0);
        chk("vol0_low_sample",  32'(sample1), 32'd0);
        chk("vol0_low_edge",    32'(edge1),   32'd1);
        cyc(3);
        en1 = 1'b0;
        cyc(3);
        chk("hi_to_idle_wave", 32'(wave1), 32'd0);
        chk("hi_to_idle_edge", 32'(edge1), 32'd1);
        chk("hi_to_idle_busy", 32'(busy1), 32'd0);

        // Asynchronous reset in the middle of a HIGH half, between clock edges.
        en1 = 1'b1; hp1 = 8'd20; vol1 = 7'd50;
        cyc(1);
        chk("rst_pre_busy", 32'(busy1), 32'd1);
        cyc(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wave",   32'(wave1),   32'd0);
        chk("rst_async_sample", 32'(sample1), 32'd0);
        chk("rst_async_busy",   32'(busy1),   32'd0);
        chk("rst_async_edge",   32'(edge1),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_busy", 32'(busy1), 32'd0);
        cyc(1);
        chk("rst_restart_busy",   32'(busy1),   32'd1);
        chk("rst_restart_wave",   32'(wave1),   32'd1);
        chk("rst_restart_sample", 32'(sample1), 32'h32);

        // PRESCALE=4: half_period=0 never starts a tone.
        en1 = 1'b0;
        en4 = 1'b1; hp4 = 8'd0; vol4 = 7'd20;
        ecount = 0;
        bcount = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            ecount = ecount + (edge4 ? 1 : 0);
            bcount = bcount + (busy4 ? 1 : 0);
        end
        chk("hp0_no_edges", 32'(ecount), 32'd0);
        chk("hp0_no_busy",  32'(bcount), 32'd0);

        // PRESCALE=4 fastest tone: first tick 4 cycles after release, toggling every 4.
        rst_n = 1'b0;
        hp4 = 8'd1;
        cyc(1);
        rst_n = 1'b1;
        bcount = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            bcount = bcount + (busy4 ? 1 : 0);
        end
        chk("ps4_wait_first_tick", 32'(bcount), 32'd0);
        cyc(1);
        chk("ps4_first_wave",   32'(wave4),   32'd1);
        chk("ps4_first_busy",   32'(busy4),   32'd1);
        chk("ps4_first_edge",   32'(edge4),   32'd1);
        chk("ps4_first_sample", 32'(sample4), 32'h14);
        cyc(1);
        chk("ps4_hold_edge", 32'(edge4), 32'd0);
        chk("ps4_hold_wave", 32'(wave4), 32'd1);
        cyc(3);
        chk("ps4_low_wave",   32'(wave4),   32'd0);
        chk("ps4_low_edge",   32'(edge4),   32'd1);
        chk("ps4_low_sample", 32'(sample4), 32'hEC);
        cyc(4);
        chk("ps4_high2_wave", 32'(wave4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
